// File: rtl/anim_pkg.sv
// Shared animation definitions: motion FSM state encoding and the default
// fixed-point step format reused by the pattern cores for position math.
package anim_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STOPPING = 2'd1,
    ST_PAUSED   = 2'd2
  } state_t;

  localparam int DEF_FRAC_BITS = 2;
  localparam int DEF_MAX_STEP  = 6;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector; the history flop reset value is chosen so a
// level already high at reset release does not look like an edge.
module edge_rise #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/motion_rate_ctrl.sv
// Frame-rate motion controller: ramped fixed-point step, phase accumulator that
// emits whole-pixel advances per frame, ramped pause and single-frame stepping.
module motion_rate_ctrl
  import anim_pkg::*;
#(
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int MAX_STEP   = DEF_MAX_STEP,
  parameter int SPEED_W    = 3,
  parameter int RAMP_EN    = 1,
  localparam int STEP_W    = $clog2(MAX_STEP + 1),
  localparam int ADV_W     = STEP_W - FRAC_BITS + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  input  logic               resume,
  input  logic               step_req,
  output logic               paused,
  output logic               stopping,
  output logic [STEP_W-1:0]  step_size,
  output logic               frame_tick,
  output logic [ADV_W-1:0]   advance
);

  localparam logic [STEP_W-1:0] ONE = STEP_W'(1);

  state_t              state;
  logic                fe;
  logic                fire;
  logic                armed;
  logic [FRAC_BITS-1:0] frac;
  logic [STEP_W-1:0]   target;
  logic [STEP_W-1:0]   step_ramp;
  logic [STEP_W-1:0]   step_dn;
  logic [STEP_W-1:0]   step_acc;
  logic [STEP_W:0]     sum;

  edge_rise #(.RST_VAL(1'b1)) u_vsync_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (vsync),
    .rise (fe)
  );

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    target = ONE;
    if (speed != '0 && int'(speed) <= MAX_STEP) target = STEP_W'(speed);

    step_ramp = target;
    if (RAMP_EN != 0) begin
      step_ramp = step_size;
      if (step_size < target)      step_ramp = step_size + ONE;
      else if (step_size > target) step_ramp = step_size - ONE;
    end

    step_dn = (step_size == '0) ? '0 : step_size - ONE;

    // The accumulator always adds the step that applies to this frame.
    case (state)
      ST_STOPPING: step_acc = step_dn;
      ST_PAUSED:   step_acc = target;
      default:     step_acc = step_ramp;
    endcase

    sum  = (STEP_W + 1)'(frac) + (STEP_W + 1)'(step_acc);
    fire = fe & ((state != ST_PAUSED) | armed);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      paused     <= 1'b0;
      stopping   <= 1'b0;
      step_size  <= '0;
      frac       <= '0;
      frame_tick <= 1'b0;
      advance    <= '0;
      armed      <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      advance    <= '0;
      if (fire) begin
        frac       <= sum[FRAC_BITS-1:0];
        advance    <= sum[STEP_W:FRAC_BITS];
        frame_tick <= 1'b1;
      end

      case (state)
        ST_RUN: begin
          if (fe) step_size <= step_ramp;
          if (pause) begin
            if (RAMP_EN != 0) begin
              state    <= ST_STOPPING;
              stopping <= 1'b1;
            end else begin
              state     <= ST_PAUSED;
              paused    <= 1'b1;
              step_size <= '0;
            end
          end
        end

        ST_STOPPING: begin
          if (fe) begin
            step_size <= step_dn;
            if (step_dn == '0) begin
              state    <= ST_PAUSED;
              stopping <= 1'b0;
              paused   <= 1'b1;
            end
          end
          // An explicit resume outranks the ramp reaching zero on the same edge.
          if (resume && !pause) begin
            state    <= ST_RUN;
            stopping <= 1'b0;
            paused   <= 1'b0;
          end
        end

        ST_PAUSED: begin
          if (fe && armed)       armed <= 1'b0;
          if (step_req && !armed) armed <= 1'b1;
          if (resume && !pause) begin
            state     <= ST_RUN;
            paused    <= 1'b0;
            step_size <= '0;
            armed     <= 1'b0;
          end
        end

        default: begin
          state    <= ST_RUN;
          paused   <= 1'b0;
          stopping <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_rate_ctrl.sv
// Bench for motion_rate_ctrl: a ramped and a jump-mode instance share stimulus
// and are compared every cycle against a frame-level model, plus literal checks.
module tb_motion_rate_ctrl;

  localparam int M_RUN   = 0;
  localparam int M_STOP  = 1;
  localparam int M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic [2:0] speed = 3'd4;
  logic       pause = 1'b0;
  logic       resume = 1'b0;
  logic       step_req = 1'b0;

  logic       paused0, stopping0, tick0, paused1, stopping1, tick1;
  logic [2:0] step0, step1;
  logic [1:0] adv0, adv1;

  int n_pass = 0;
  int n_total = 0;
  bit started = 1'b0;

  int m_mode[2], m_step[2], m_frac[2], m_armed[2], m_pv[2], m_tick[2], m_adv[2];
  int q_step0[$], q_adv0[$], q_step1[$];

  always #5 clk = ~clk;

  motion_rate_ctrl #(.RAMP_EN(1)) u_ramp (
    .clk(clk), .rst(rst), .vsync(vsync), .speed(speed), .pause(pause),
    .resume(resume), .step_req(step_req), .paused(paused0), .stopping(stopping0),
    .step_size(step0), .frame_tick(tick0), .advance(adv0)
  );

  motion_rate_ctrl #(.RAMP_EN(0)) u_jump (
    .clk(clk), .rst(rst), .vsync(vsync), .speed(speed), .pause(pause),
    .resume(resume), .step_req(step_req), .paused(paused1), .stopping(stopping1),
    .step_size(step1), .frame_tick(tick1), .advance(adv1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic emit(input int i, input int s);
    int total;
    total     = m_frac[i] + s;
    m_adv[i]  = total / 4;
    m_frac[i] = total % 4;
    m_tick[i] = 1;
  endtask

  // One clock of the frame-level behaviour, from the pre-edge state.
  task automatic model_update(input int i);
    int  tgt, ns, mode0, armed0;
    bit  fe, ramp;
    ramp = (i == 0);
    m_tick[i] = 0;
    m_adv[i]  = 0;
    if (rst) begin
      m_mode[i] = M_RUN; m_step[i] = 0; m_frac[i] = 0; m_armed[i] = 0; m_pv[i] = 1;
      return;
    end
    fe = vsync && !m_pv[i];
    m_pv[i] = vsync;
    tgt = (int'(speed) >= 1 && int'(speed) <= 6) ? int'(speed) : 1;
    mode0  = m_mode[i];
    armed0 = m_armed[i];
    if (fe) begin
      if (mode0 == M_RUN) begin
        if (!ramp)                ns = tgt;
        else if (m_step[i] < tgt) ns = m_step[i] + 1;
        else if (m_step[i] > tgt) ns = m_step[i] - 1;
        else                      ns = m_step[i];
        m_step[i] = ns;
        emit(i, ns);
      end else if (mode0 == M_STOP) begin
        ns = (m_step[i] > 0) ? m_step[i] - 1 : 0;
        m_step[i] = ns;
        emit(i, ns);
        if (ns == 0) m_mode[i] = M_PAUSE;
      end else if (armed0 != 0) begin
        emit(i, tgt);
        m_armed[i] = 0;
      end
    end
    if (mode0 == M_RUN) begin
      if (pause) begin
        if (ramp) m_mode[i] = M_STOP;
        else begin m_mode[i] = M_PAUSE; m_step[i] = 0; end
      end
    end else if (mode0 == M_STOP) begin
      if (resume && !pause) m_mode[i] = M_RUN;
    end else begin
      if (step_req && armed0 == 0) m_armed[i] = 1;
      if (resume && !pause) begin m_mode[i] = M_RUN; m_step[i] = 0; m_armed[i] = 0; end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_update(i);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("ramp.frame_tick", int'(tick0), m_tick[0]);
      check("ramp.advance", int'(adv0), m_adv[0]);
      check("ramp.step_size", int'(step0), m_step[0]);
      check("ramp.paused", int'(paused0), int'(m_mode[0] == M_PAUSE));
      check("ramp.stopping", int'(stopping0), int'(m_mode[0] == M_STOP));
      check("jump.frame_tick", int'(tick1), m_tick[1]);
      check("jump.advance", int'(adv1), m_adv[1]);
      check("jump.step_size", int'(step1), m_step[1]);
      check("jump.paused", int'(paused1), int'(m_mode[1] == M_PAUSE));
      check("jump.stopping", int'(stopping1), int'(m_mode[1] == M_STOP));
      if (tick0) begin q_step0.push_back(int'(step0)); q_adv0.push_back(int'(adv0)); end
      if (tick1) q_step1.push_back(int'(step1));
    end
  end

  task automatic clear_logs();
    q_step0.delete(); q_adv0.delete(); q_step1.delete();
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      @(negedge clk) vsync = 1'b1;
      repeat (2) @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic one_cycle_req(input bit p, input bit r, input bit s);
    @(negedge clk);
    pause = p; resume = r; step_req = s;
    @(negedge clk);
    pause = 1'b0; resume = 1'b0; step_req = 1'b0;
  endtask

  initial begin
    int exp_step[6];
    int exp_adv[6];
    int vcnt;
    exp_step = '{1, 2, 3, 4, 4, 4};
    exp_adv  = '{0, 0, 1, 1, 1, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset.step_size", int'(step0), 0);
    check("reset.frame_tick", int'(tick0), 0);
    check("reset.paused", int'(paused0), 0);

    // Ramp up to speed 4 from reset.
    clear_logs();
    pulses(6);
    check("ramp_up.ticks", q_step0.size(), 6);
    for (int k = 0; k < 6 && k < q_step0.size(); k++) begin
      check($sformatf("ramp_up.step[%0d]", k), q_step0[k], exp_step[k]);
      check($sformatf("ramp_up.adv[%0d]", k), q_adv0[k], exp_adv[k]);
    end
    check("ramp_up.model_frac", m_frac[0], 2);

    // Ramped pause: four ticks down to zero, then silence.
    one_cycle_req(1'b1, 1'b0, 1'b0);
    check("pause.stopping", int'(stopping0), 1);
    check("pause.jump_paused", int'(paused1), 1);
    clear_logs();
    pulses(4);
    check("stop.ticks", q_step0.size(), 4);
    if (q_step0.size() == 4) begin
      check("stop.step0", q_step0[0], 3);
      check("stop.step3", q_step0[3], 0);
      check("stop.adv0", q_adv0[0], 1);
      check("stop.adv2", q_adv0[2], 1);
    end
    check("stop.paused", int'(paused0), 1);
    check("stop.stopping", int'(stopping0), 0);
    clear_logs();
    pulses(1);
    check("paused.no_tick", q_step0.size(), 0);

    // Single-frame steps at speed 6 while paused.
    speed = 3'd6;
    one_cycle_req(1'b0, 1'b0, 1'b1);
    clear_logs();
    pulses(1);
    check("step1.ticks", q_adv0.size(), 1);
    if (q_adv0.size() == 1) check("step1.adv", q_adv0[0], 1);
    check("step1.model_frac", m_frac[0], 2);
    one_cycle_req(1'b0, 1'b0, 1'b1);
    clear_logs();
    pulses(1);
    check("step2.ticks", q_adv0.size(), 1);
    if (q_adv0.size() == 1) check("step2.adv", q_adv0[0], 2);
    check("step2.model_frac", m_frac[0], 0);
    check("step2.paused", int'(paused0), 1);
    check("step2.step_size", int'(step0), 0);
    clear_logs();
    pulses(1);
    check("step_done.no_tick", q_adv0.size(), 0);

    // Resume, then out-of-range speeds settle at step 1.
    one_cycle_req(1'b0, 1'b1, 1'b0);
    check("resume.paused", int'(paused0), 0);
    speed = 3'd0;
    pulses(3);
    check("speed0.step", int'(step0), 1);
    speed = 3'd7;
    pulses(2);
    check("speed7.step", int'(step0), 1);
    check("speed7.jump_step", int'(step1), 1);

    // Jump mode loads the target immediately.
    speed = 3'd2;
    pulses(1);
    check("jump.step2", int'(step1), 2);
    speed = 3'd6;
    clear_logs();
    pulses(1);
    if (q_step1.size() == 1) check("jump.tick_step6", q_step1[0], 6);
    else check("jump.tick_count", q_step1.size(), 1);
    check("ramp.step3", int'(step0), 3);

    // Pause and resume together: pause wins.
    one_cycle_req(1'b1, 1'b1, 1'b0);
    check("pause_prio.stopping", int'(stopping0), 1);
    check("pause_prio.jump_paused", int'(paused1), 1);

    // Reset mid-STOPPING with vsync held high across release.
    pulses(1);
    @(negedge clk);
    rst = 1'b1; vsync = 1'b1;
    @(negedge clk);
    check("rst_mid.stopping", int'(stopping0), 0);
    check("rst_mid.step", int'(step0), 0);
    check("rst_mid.tick", int'(tick0), 0);
    check("rst_mid.adv", int'(adv0), 0);
    check("rst_mid.paused", int'(paused0), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (4) @(negedge clk);
    check("vsync_high.no_tick", q_step0.size(), 0);
    vsync = 1'b0;
    pulses(1);
    check("vsync_edge.ticks", q_step0.size(), 1);
    if (q_step0.size() == 1) check("vsync_edge.step", q_step0[0], 1);

    // Randomised traffic, compared cycle by cycle against the model.
    vcnt = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (vcnt == 0) begin
        vsync = ~vsync;
        vcnt  = vsync ? $urandom_range(1, 3) : $urandom_range(1, 8);
      end else vcnt--;
      pause    = ($urandom_range(0, 19) == 0);
      resume   = ($urandom_range(0, 14) == 0);
      step_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) speed = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk);
    rst = 1'b0; pause = 1'b0; resume = 1'b0; step_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/motion_rate_ctrl.md
# motion_rate_ctrl

Parametrised frame-rate motion controller for the pattern generators. It replaces fixed speed-to-step mapping with a configurable fixed-point step and a per-frame acceleration ramp. It also adds a phase accumulator that emits whole-pixel advances, a ramped pause, and a single-frame step while paused. It sits between the VGA timing block (vsync) and the pattern cores, which consume `frame_tick` and `advance`.

## Interface
- `FRAC_BITS`, default 2: fractional bits of step and accumulator (Q(STEP_W-FRAC_BITS).FRAC_BITS).
- `MAX_STEP`, default 6: largest legal step code; also the width reference, `STEP_W = $clog2(MAX_STEP+1)`.
- `SPEED_W`, default 3: width of the `speed` input.
- `RAMP_EN`, default 1: 1 = step ramps ±1 per frame; 0 = step jumps to its target.
- `ADV_W` (derived): `STEP_W - FRAC_BITS + 1`.

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `vsync`  in  1  vsync from the timing block, same clock domain, level.
- `speed`  in  SPEED_W  requested speed code.
- `pause`  in  1  pause request, level-sampled each cycle.
- `resume`  in  1  resume request, level-sampled each cycle.
- `step_req`  in  1  request one frame of motion while paused.
- `paused`  out  1  high only in PAUSED.
- `stopping`  out  1  high only in STOPPING.
- `step_size`  out  STEP_W  current (ramped) step.
- `frame_tick`  out  1  one-cycle pulse; the pattern advances this frame.
- `advance`  out  ADV_W  whole pixels to move; valid only with `frame_tick`, otherwise 0.

## Operation
- **Target step.**
  - `target = speed` when `1 <= speed <= MAX_STEP`.
  - Otherwise `target = 1` (covers speed 0 and out-of-range codes).
  - Combinational; a speed change takes effect on the next frame.
- **Frame edge.** `fe = vsync & ~vsync_q`. `vsync_q` resets to 1, so a vsync held high through reset produces no edge.
- **FSM states:** RUN (reset state), STOPPING, PAUSED.
- **RUN, on `fe`:**
  - `step_size` moves one toward `target`: +1, −1 or hold. With RAMP_EN=0 it loads `target`.
  - Accumulate using the new step: `sum = frac + step_new`.
  - `advance = sum >> FRAC_BITS`; `frac = sum[FRAC_BITS-1:0]`; `frame_tick` pulses.
- **RUN, on `pause`:**
  - RAMP_EN=1: go to STOPPING.
  - RAMP_EN=0: go to PAUSED and `step_size` becomes 0.
- **STOPPING, on `fe`:**
  - `step_size` decrements by 1 and accumulation runs as above, so ticks continue.
  - When the new step is 0, go to PAUSED on the same edge.
  - `resume` returns to RUN; ramping continues upward from the current step.
- **PAUSED:**
  - No ticks on `fe`; `frac` is held.
  - `resume` goes to RUN with `step_size` 0, which then ramps up.
  - `step_req` arms a one-shot. On the next `fe`, one tick is produced with `sum = frac + target` (no ramp, `step_size` stays 0). The FSM stays PAUSED and the one-shot clears.
  - A second `step_req` while armed is ignored. `step_req` is ignored outside PAUSED.
- **Simultaneous events:**
  - `pause` has priority over `resume` in the same cycle.
  - A request and `fe` in the same cycle: the state transition and the frame update both use the pre-transition state.

## Timing
- `vsync` sampled high at cycle t and low at t−1 → `frame_tick`, `advance`, `step_size` and state all update at the clock edge ending cycle t, and are visible in cycle t+1. Latency is 1 cycle from the sampled edge.
- `frame_tick` is exactly one cycle wide, at most one per vsync rising edge.
- `paused` and `stopping` are registered and change one cycle after the causing request, or at the terminating `fe`.
- **Reset values:** state RUN, `paused`=0, `stopping`=0, `step_size`=0, `frac`=0, `frame_tick`=0, `advance`=0, `vsync_q`=1, step one-shot clear. Reset mid-STOPPING or mid-armed-step discards all of it.
- **Width rules:**
  - `sum` is STEP_W+1 bits; no overflow is possible because `frac < 2^FRAC_BITS`.
  - `step_size` never exceeds MAX_STEP and never underflows below 0.

## Structure
- Shared package `anim_pkg`:
  - state encoding (`ST_RUN`, `ST_STOPPING`, `ST_PAUSED`);
  - default FRAC_BITS and MAX_STEP constants, which the pattern cores reuse for position math.
- Sub-module `edge_rise` (registered rising-edge detector with a parametrised reset value), reused by other vsync consumers.
- Everything else, including the FSM, ramp and accumulator, is in this module.

## Test plan
Defaults unless stated (FRAC_BITS=2, MAX_STEP=6, RAMP_EN=1).
- Reset, `speed`=4, 6 vsync pulses → `step_size` 1,2,3,4,4,4; `advance` 0,0,1,1,1,1; final `frac`=2.
- Steady at step 4, assert `pause` → `stopping`=1. Next 4 ticks have step 3,2,1,0. `paused`=1 from the tick at step 0; the following vsyncs give no `frame_tick`.
- PAUSED with `frac`=2, `speed`=6, `step_req` then vsync → exactly one tick with `advance`=2 and `frac` 0. `paused` stays 1; the next vsync gives no tick.
- `pause` and `resume` asserted in the same cycle while in RUN → STOPPING entered.
- `speed`=0 and then `speed`=7 → `step_size` settles at 1. With RAMP_EN=0 and `speed` 2→6, the next tick has `step_size`=6 immediately.
- `vsync` high during reset and still high after release → no tick until vsync falls and rises again. `rst` asserted mid-STOPPING → all outputs return to reset values next cycle.
